// File: rtl/dac_serializer.sv
//==============================================================================
// Module   : dac_serializer
// Brief    : Converts signed samples to offset binary and shifts them out as
//            24-bit SPI frames to a dual 16-bit DAC, then pulses LDAC.
//            Macro DAC_SERIALIZER_DUAL_CH_EN enables the second (ch1) frame.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dac_serializer #(
    parameter int M       = 16,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2,
    parameter int LDAC_W  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [M-1:0] ch0,
    input  logic [M-1:0] ch1,
    output logic         ready,
    output logic         dac_sclk,
    output logic         dac_cs_n,
    output logic         dac_sdo,
    output logic         dac_ldac_n,
    output logic [7:0]   overrun_cnt
);

    localparam int c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_WAIT_MAX = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
    localparam int c_WAIT_W   = $clog2(c_WAIT_MAX + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_LDAC_LAST = c_WAIT_W'(LDAC_W - 1);
    localparam logic [4:0]          c_LAST_BIT  = 5'd23;
    localparam logic [7:0]          c_CMD_CH0   = 8'h30;
`ifdef DAC_SERIALIZER_DUAL_CH_EN
    localparam logic [c_WAIT_W-1:0] c_GAP_LAST  = c_WAIT_W'(CS_GAP - 1);
    localparam logic [7:0]          c_CMD_CH1   = 8'h31;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT0 = 3'd1,
        S_GAP    = 3'd2,
        S_SHIFT1 = 3'd3,
        S_LDAC   = 3'd4
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [c_DIV_W-1:0]  r_div,    w_div_nxt;
    logic                r_phase,  w_phase_nxt;
    logic [4:0]          r_bit,    w_bit_nxt;
    logic [c_WAIT_W-1:0] r_wait,   w_wait_nxt;
    logic [23:0]         r_shreg,  w_shreg_nxt;

    logic                r_ready;
    logic                r_sclk;
    logic                r_cs_n;
    logic                r_sdo;
    logic                r_ldac_n;
    logic [7:0]          r_ovr;

    logic                w_accept;
    logic                w_overrun;
    logic                w_in_shift;
    logic [15:0]         w_data0;

    // Offset binary, left-justified into the DAC's 16-bit data field.
    function automatic logic [15:0] to_dac_data(input logic [M-1:0] x);
        logic [15:0] d;
        d          = 16'h0000;
        d[15 -: M] = {~x[M-1], x[M-2:0]};
        return d;
    endfunction

    assign w_accept   = sample_valid && r_ready;
    assign w_overrun  = sample_valid && !r_ready;
    assign w_in_shift = (r_state == S_SHIFT0) || (r_state == S_SHIFT1);
    assign w_data0    = to_dac_data(ch0);

`ifdef DAC_SERIALIZER_DUAL_CH_EN
    logic [15:0] r_data1;
    logic [15:0] w_data1;
    assign w_data1 = to_dac_data(ch1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data1 <= 16'h0000;
        end else if (w_accept) begin
            r_data1 <= w_data1;
        end
    end
`else
    logic w_unused_ch1;
    assign w_unused_ch1 = ^ch1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_wait_nxt  = r_wait;
        w_shreg_nxt = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT0;
                    w_shreg_nxt = {c_CMD_CH0, w_data0};
                    w_div_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = '0;
                end
            end
            S_SHIFT0, S_SHIFT1: begin
                if (r_div != c_DIV_LAST) begin
                    w_div_nxt = r_div + 1'b1;
                end else begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (r_bit != c_LAST_BIT) begin
                            w_bit_nxt   = r_bit + 1'b1;
                            w_shreg_nxt = {r_shreg[22:0], 1'b0};
                        end else begin
                            w_wait_nxt = '0;
`ifdef DAC_SERIALIZER_DUAL_CH_EN
                            w_state_nxt = (r_state == S_SHIFT0) ? S_GAP : S_LDAC;
`else
                            w_state_nxt = S_LDAC;
`endif
                        end
                    end
                end
            end
`ifdef DAC_SERIALIZER_DUAL_CH_EN
            S_GAP: begin
                if (r_wait == c_GAP_LAST) begin
                    w_state_nxt = S_SHIFT1;
                    w_shreg_nxt = {c_CMD_CH1, r_data1};
                    w_div_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = '0;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
`endif
            S_LDAC: begin
                if (r_wait == c_LDAC_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pins are registered from the current state, so they lag the state by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_phase  <= 1'b0;
            r_bit    <= '0;
            r_wait   <= '0;
            r_shreg  <= '0;
            r_ready  <= 1'b1;
            r_sclk   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sdo    <= 1'b0;
            r_ldac_n <= 1'b1;
            r_ovr    <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_phase  <= w_phase_nxt;
            r_bit    <= w_bit_nxt;
            r_wait   <= w_wait_nxt;
            r_shreg  <= w_shreg_nxt;
            r_ready  <= (r_state == S_IDLE) && !w_accept;
            r_sclk   <= w_in_shift && r_phase;
            r_cs_n   <= !w_in_shift;
            r_sdo    <= w_in_shift && r_shreg[23];
            r_ldac_n <= (r_state != S_LDAC);
            if (w_overrun && (r_ovr != 8'hFF)) begin
                r_ovr <= r_ovr + 8'd1;
            end
        end
    end

    assign ready       = r_ready;
    assign dac_sclk    = r_sclk;
    assign dac_cs_n    = r_cs_n;
    assign dac_sdo     = r_sdo;
    assign dac_ldac_n  = r_ldac_n;
    assign overrun_cnt = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_dac_serializer.sv
//==============================================================================
// Module   : tb_dac_serializer
// Brief    : Directed self-checking bench for dac_serializer (default and
//            M=12/CLK_DIV=1 instances); follows DAC_SERIALIZER_DUAL_CH_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dac_serializer;

    localparam int REC_N = 200;
`ifdef DAC_SERIALIZER_DUAL_CH_EN
    localparam int         EXP_NFR = 2;
    localparam logic [7:0] EXP_CS  = 8'b10011001;
    localparam int         LD      = 195;
    localparam int         RD      = 197;
    localparam int         S3      = 150;
    localparam int         EXP_R1  = 24;
`else
    localparam int         EXP_NFR = 1;
    localparam logic [7:0] EXP_CS  = 8'b10011111;
    localparam int         LD      = 97;
    localparam int         RD      = 99;
    localparam int         S3      = 90;
    localparam int         EXP_R1  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sv, sv12;
    logic [15:0] a, b;
    logic [11:0] a12, b12;
    logic        rdy, sclk, csn, sdo, ldacn;
    logic        rdy12, sclk12, csn12, sdo12, ldacn12;
    logic [7:0]  ovr, ovr12;

    int errors = 0;
    int checks = 0;

    logic        tr_cs [0:REC_N-1];
    logic        tr_sclk [0:REC_N-1];
    logic        tr_sdo [0:REC_N-1];
    logic        tr_ldac [0:REC_N-1];
    logic        tr_rdy [0:REC_N-1];
    logic [23:0] dec_fr [0:3];
    int          dec_rise [0:3];
    int          dec_win [0:3];
    int          dec_n, dec_unstable;

    always #5 clk = ~clk;

    dac_serializer dut (
        .clk(clk), .rst(rst_n), .sample_valid(sv), .ch0(a), .ch1(b),
        .ready(rdy), .dac_sclk(sclk), .dac_cs_n(csn), .dac_sdo(sdo),
        .dac_ldac_n(ldacn), .overrun_cnt(ovr)
    );

    dac_serializer #(.M(12), .CLK_DIV(1), .CS_GAP(2), .LDAC_W(2)) dut12 (
        .clk(clk), .rst(rst_n), .sample_valid(sv12), .ch0(a12), .ch1(b12),
        .ready(rdy12), .dac_sclk(sclk12), .dac_cs_n(csn12), .dac_sdo(sdo12),
        .dac_ldac_n(ldacn12), .overrun_cnt(ovr12)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Strobe one sample; the edge that accepts it is T0. Inputs are then scrambled.
    task automatic send(input bit use12, input logic [15:0] c0, input logic [15:0] c1);
        @(negedge clk);
        if (use12) begin
            sv12 = 1'b1; a12 = c0[11:0]; b12 = c1[11:0];
        end else begin
            sv = 1'b1; a = c0; b = c1;
        end
        @(posedge clk);
        #1;
        sv = 1'b0; sv12 = 1'b0;
        a = ~c0; b = ~c1; a12 = ~c0[11:0]; b12 = ~c1[11:0];
    endtask

    // Entry k of the trace is the interval following edge T0+k.
    task automatic record(input bit use12, input int s1, input int s2, input int s3);
        for (int k = 0; k < REC_N; k++) begin
            @(negedge clk);
            tr_cs[k]   = use12 ? csn12   : csn;
            tr_sclk[k] = use12 ? sclk12  : sclk;
            tr_sdo[k]  = use12 ? sdo12   : sdo;
            tr_ldac[k] = use12 ? ldacn12 : ldacn;
            tr_rdy[k]  = use12 ? rdy12   : rdy;
            if ((k + 1 == s1) || (k + 1 == s2) || (k + 1 == s3)) begin
                sv = 1'b1; a = 16'h5555; b = 16'hAAAA;
            end else begin
                sv = 1'b0;
            end
        end
        sv = 1'b0;
    endtask

    // Rebuild frames as the DAC sees them: sdo taken on each sclk rise inside a cs_n window.
    task automatic decode();
        dec_n = 0;
        dec_unstable = 0;
        for (int i = 0; i < 4; i++) begin
            dec_fr[i] = 24'h0; dec_rise[i] = 0; dec_win[i] = 0;
        end
        for (int k = 1; k < REC_N; k++) begin
            if (tr_cs[k] == 1'b0) begin
                if (tr_cs[k-1] == 1'b1) dec_n++;
                if (dec_n >= 1 && dec_n <= 4) begin
                    dec_win[dec_n-1]++;
                    if (tr_sclk[k] == 1'b1 && tr_sclk[k-1] == 1'b0) begin
                        dec_fr[dec_n-1] = {dec_fr[dec_n-1][22:0], tr_sdo[k]};
                        dec_rise[dec_n-1]++;
                        if (tr_sdo[k] !== tr_sdo[k-1]) dec_unstable++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [12:0] got, exp;
        rst_n = 1'b0; sv = 1'b0; sv12 = 1'b0;
        a = 16'h0; b = 16'h0; a12 = 12'h0; b12 = 12'h0;
        repeat (3) @(negedge clk);
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        got = {rdy, sclk, csn, sdo, ldacn, ovr};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_main: got %b expected %b", got, exp);
        end
        got = {rdy12, sclk12, csn12, sdo12, ldacn12, ovr12};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_m12: got %b expected %b", got, exp);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] gcs;
        logic [3:0] gld;
        logic [2:0] grd;
        send(1'b0, 16'h0000, 16'h8000);
        record(1'b0, -1, -1, -1);
        decode();
        checks++;
        if (dec_n !== EXP_NFR) begin
            errors++; $display("FAIL basic_nframes: got %0d expected %0d", dec_n, EXP_NFR);
        end
        checks++;
        if (dec_fr[0] !== 24'h308000) begin
            errors++; $display("FAIL basic_frame0: got %h expected 308000", dec_fr[0]);
        end
        checks++;
`ifdef DAC_SERIALIZER_DUAL_CH_EN
        if (dec_fr[1] !== 24'h310000) begin
            errors++; $display("FAIL basic_frame1: got %h expected 310000", dec_fr[1]);
        end
`else
        if (dec_fr[1] !== 24'h000000) begin
            errors++; $display("FAIL basic_frame1: got %h expected none", dec_fr[1]);
        end
`endif
        gcs = {tr_cs[0], tr_cs[1], tr_cs[96], tr_cs[97], tr_cs[98], tr_cs[99], tr_cs[194], tr_cs[195]};
        checks++;
        if (gcs !== EXP_CS) begin
            errors++; $display("FAIL basic_cs_edges: got %b expected %b", gcs, EXP_CS);
        end
        gld = {tr_ldac[LD-1], tr_ldac[LD], tr_ldac[LD+1], tr_ldac[LD+2]};
        checks++;
        if (gld !== 4'b1001) begin
            errors++; $display("FAIL basic_ldac_edges: got %b expected 1001", gld);
        end
        grd = {tr_rdy[0], tr_rdy[RD-1], tr_rdy[RD]};
        checks++;
        if (grd !== 3'b001) begin
            errors++; $display("FAIL basic_ready_edges: got %b expected 001", grd);
        end
    endtask

    task automatic test_full_scale();
        send(1'b0, 16'h7FFF, 16'h8001);
        record(1'b0, -1, -1, -1);
        decode();
        checks++;
        if (dec_fr[0] !== 24'h30FFFF) begin
            errors++; $display("FAIL fs_frame0: got %h expected 30ffff", dec_fr[0]);
        end
        checks++;
`ifdef DAC_SERIALIZER_DUAL_CH_EN
        if (dec_fr[1] !== 24'h310001) begin
            errors++; $display("FAIL fs_frame1: got %h expected 310001", dec_fr[1]);
        end
`else
        if (dec_fr[1] !== 24'h000000) begin
            errors++; $display("FAIL fs_frame1: got %h expected none", dec_fr[1]);
        end
`endif
        checks++;
        if (dec_rise[0] !== 24 || dec_rise[1] !== EXP_R1) begin
            errors++;
            $display("FAIL fs_rises: got %0d/%0d expected 24/%0d", dec_rise[0], dec_rise[1], EXP_R1);
        end
        checks++;
        if (dec_unstable !== 0) begin
            errors++; $display("FAIL fs_sdo_stable: got %0d changes expected 0", dec_unstable);
        end
        checks++;
        if (dec_win[0] !== 96) begin
            errors++; $display("FAIL fs_cs_window: got %0d expected 96", dec_win[0]);
        end
    endtask

    task automatic test_overrun();
        int n;
        send(1'b0, 16'h1234, 16'hFEDC);
        record(1'b0, 10, 50, S3);
        decode();
        checks++;
        if (ovr !== 8'd3) begin
            errors++; $display("FAIL ovr_count3: got %0d expected 3", ovr);
        end
        checks++;
        if (dec_n !== EXP_NFR || dec_fr[0] !== 24'h309234) begin
            errors++; $display("FAIL ovr_frame0: got %h (n=%0d) expected 309234", dec_fr[0], dec_n);
        end
`ifdef DAC_SERIALIZER_DUAL_CH_EN
        checks++;
        if (dec_fr[1] !== 24'h317EDC) begin
            errors++; $display("FAIL ovr_frame1: got %h expected 317edc", dec_fr[1]);
        end
`endif
        @(negedge clk);
        sv = 1'b1; a = 16'h0F0F; b = 16'hF0F0;
        repeat (320) @(negedge clk);
        sv = 1'b0;
        checks++;
        if (ovr !== 8'd255) begin
            errors++; $display("FAIL ovr_saturate: got %0d expected 255", ovr);
        end
        n = 0;
        while (rdy !== 1'b1 && n < 250) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy !== 1'b1 || ovr !== 8'd255) begin
            errors++; $display("FAIL ovr_idle: ready=%b cnt=%0d expected ready=1 cnt=255", rdy, ovr);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] got, exp;
        send(1'b0, 16'h1111, 16'h2222);
        repeat (32) @(negedge clk);
        checks++;
        if ({csn, sclk} !== 2'b01) begin
            errors++; $display("FAIL mid_pre_reset: got cs_n,sclk=%b expected 01", {csn, sclk});
        end
        #2 rst_n = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        got = {rdy, sclk, csn, sdo, ldacn, ovr};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mid_async_reset: got %b expected %b", got, exp);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 16'hC000, 16'h0001);
        record(1'b0, -1, -1, -1);
        decode();
        checks++;
        if (dec_n !== EXP_NFR || dec_fr[0] !== 24'h304000) begin
            errors++; $display("FAIL mid_frame0: got %h (n=%0d) expected 304000", dec_fr[0], dec_n);
        end
`ifdef DAC_SERIALIZER_DUAL_CH_EN
        checks++;
        if (dec_fr[1] !== 24'h318001) begin
            errors++; $display("FAIL mid_frame1: got %h expected 318001", dec_fr[1]);
        end
`endif
    endtask

    task automatic test_param_sweep();
        send(1'b1, 16'h07FF, 16'h0000);
        record(1'b1, -1, -1, -1);
        decode();
        checks++;
        if (dec_fr[0] !== 24'h30FFF0) begin
            errors++; $display("FAIL m12_max_frame0: got %h expected 30fff0", dec_fr[0]);
        end
        checks++;
        if (dec_win[0] !== 48 || dec_rise[0] !== 24 || dec_unstable !== 0) begin
            errors++;
            $display("FAIL m12_window: got win=%0d rises=%0d unstable=%0d expected 48/24/0",
                     dec_win[0], dec_rise[0], dec_unstable);
        end
`ifdef DAC_SERIALIZER_DUAL_CH_EN
        checks++;
        if (dec_fr[1] !== 24'h318000 || dec_win[1] !== 48) begin
            errors++; $display("FAIL m12_frame1: got %h win=%0d expected 318000 win=48", dec_fr[1], dec_win[1]);
        end
`endif
        send(1'b1, 16'h0800, 16'h07FF);
        record(1'b1, -1, -1, -1);
        decode();
        checks++;
        if (dec_n !== EXP_NFR || dec_fr[0] !== 24'h300000) begin
            errors++; $display("FAIL m12_min_frame0: got %h (n=%0d) expected 300000", dec_fr[0], dec_n);
        end
`ifdef DAC_SERIALIZER_DUAL_CH_EN
        checks++;
        if (dec_fr[1] !== 24'h31FFF0) begin
            errors++; $display("FAIL m12_min_frame1: got %h expected 31fff0", dec_fr[1]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_overrun();
        test_reset_mid();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
